// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sharing one single-port RAM between N_PORTS requesters.
// Define MEM_ARB_FIXED_PRIO_EN to make the lowest-index pending port always win.
module mem_arbiter #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 16,
  parameter int N_PORTS = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_PORTS-1:0]            req_read,
  input  logic [N_PORTS-1:0]            req_write,
  input  logic [N_PORTS*ADDR_W-1:0]     req_addr,
  input  logic [N_PORTS*DATA_W-1:0]     req_data_w,
  output logic [DATA_W-1:0]             req_data_r,
  output logic [N_PORTS-1:0]            req_wait,
  output logic                          mem_en,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic [DATA_W-1:0]             mem_data_w,
  output logic                          mem_read,
  output logic                          mem_write,
  input  logic [DATA_W-1:0]             mem_data_r,
  input  logic                          mem_wait,
  output logic                          grant_valid,
  output logic [(N_PORTS>1 ? $clog2(N_PORTS) : 1)-1:0] grant_idx
);
  localparam int GRANT_W = N_PORTS > 1 ? $clog2(N_PORTS) : 1;
  localparam logic IDLE = 1'b0;
  localparam logic BUSY = 1'b1;
  logic               state;
  logic [N_PORTS-1:0] pending;
  logic [GRANT_W-1:0] winner;
  logic               busy, g_read, g_write;
  assign pending     = req_read | req_write;
  assign busy        = state == BUSY;
  assign g_read      = req_read[grant_idx];
  assign g_write     = req_write[grant_idx];
  assign grant_valid = busy;
  assign req_data_r  = mem_data_r;
  assign mem_en      = busy & (g_read | g_write);
  assign mem_read    = busy & g_read;
  assign mem_write   = busy & g_write;
  assign mem_addr    = busy ? req_addr[int'(grant_idx)*ADDR_W +: ADDR_W] : '0;
  assign mem_data_w  = busy ? req_data_w[int'(grant_idx)*DATA_W +: DATA_W] : '0;
  always_comb begin
    winner = grant_idx;
`ifdef MEM_ARB_FIXED_PRIO_EN
    for (int i = N_PORTS - 1; i >= 0; i--)
      if (pending[i]) winner = GRANT_W'(i);
`else
    // descending scan so the nearest port after the last grant wins
    for (int k = N_PORTS; k >= 1; k--)
      if (pending[(int'(grant_idx) + k) % N_PORTS]) winner = GRANT_W'((int'(grant_idx) + k) % N_PORTS);
`endif
  end
  always_comb begin
    req_wait = pending;
    if (busy) req_wait[grant_idx] = g_read & mem_wait;
  end
  // a write-only or dropped request always ends the access; a read ends when the RAM releases wait
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      grant_idx <= GRANT_W'(N_PORTS - 1);
    end else if (!busy) begin
      if (|pending) begin
        state     <= BUSY;
        grant_idx <= winner;
      end
    end else if (!g_read || !mem_wait) begin
      state <= IDLE;
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench for mem_arbiter with a 2-port and a 4-port instance.
module tb_mem_arbiter;
  typedef struct packed {
    logic [2:0]  port;
    logic        we;
    logic [15:0] addr;
    logic [31:0] data;
  } txn_t;
  logic        clk = 0;
  logic        rst = 1;
  logic [1:0]  rr = 0, rw = 0;
  logic [31:0] ra = 0;
  logic [63:0] rd = 0;
  logic [31:0] data_r, mem_data_w, mem_data_r;
  logic [1:0]  req_wait;
  logic        mem_en, mem_read, mem_write, mem_wait, grant_valid;
  logic [15:0] mem_addr;
  logic [0:0]  grant_idx;
  logic [3:0]  rr4 = 0, rw4 = 0;
  logic [63:0] ra4 = 0;
  logic [127:0] rd4 = 0;
  logic [31:0] data_r4, mem_data_w4, mem_data_r4;
  logic [3:0]  req_wait4;
  logic        mem_en4, mem_read4, mem_write4, grant_valid4;
  logic [15:0] mem_addr4;
  logic [1:0]  grant_idx4;
  logic [31:0] ram [0:255];
  int wait_n = 0, cnt = 0;
  int checks = 0, passes = 0, pops2 = 0, pops4 = 0;
  txn_t q2[$], q4[$];
  always #5 clk = ~clk;
  mem_arbiter dut (
    .clk(clk), .rst(rst), .req_read(rr), .req_write(rw), .req_addr(ra), .req_data_w(rd),
    .req_data_r(data_r), .req_wait(req_wait), .mem_en(mem_en), .mem_addr(mem_addr),
    .mem_data_w(mem_data_w), .mem_read(mem_read), .mem_write(mem_write),
    .mem_data_r(mem_data_r), .mem_wait(mem_wait), .grant_valid(grant_valid), .grant_idx(grant_idx)
  );
  mem_arbiter #(.N_PORTS(4)) dut4 (
    .clk(clk), .rst(rst), .req_read(rr4), .req_write(rw4), .req_addr(ra4), .req_data_w(rd4),
    .req_data_r(data_r4), .req_wait(req_wait4), .mem_en(mem_en4), .mem_addr(mem_addr4),
    .mem_data_w(mem_data_w4), .mem_read(mem_read4), .mem_write(mem_write4),
    .mem_data_r(mem_data_r4), .mem_wait(1'b0), .grant_valid(grant_valid4), .grant_idx(grant_idx4)
  );
  assign mem_wait    = mem_read && (cnt < wait_n);
  assign mem_data_r  = ram[mem_addr[7:0]];
  assign mem_data_r4 = {16'hC0DE, mem_addr4};
  always @(posedge clk) begin
    if (mem_write) ram[mem_addr[7:0]] <= mem_data_w;
    cnt <= (rst || !mem_read || !mem_wait) ? 0 : cnt + 1;
  end
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask
  function automatic txn_t mk(input int p, input logic we, input logic [15:0] a, input logic [31:0] d);
    mk = {3'(p), we, a, d};
  endfunction
  always @(negedge clk) begin
    if (!rst && grant_valid && (mem_write || (mem_read && !mem_wait))) begin
      txn_t act;
      act = mk(int'(grant_idx), mem_write, mem_addr, mem_write ? mem_data_w : data_r);
      if (q2.size() == 0) begin
        checks++;
        $display("FAIL txn2: unexpected access %0h", act);
      end else chk("txn2", 64'(act), 64'(q2.pop_front()));
      pops2++;
    end
  end
  always @(negedge clk) begin
    if (!rst && grant_valid4 && (mem_write4 || mem_read4)) begin
      txn_t act;
      act = mk(int'(grant_idx4), mem_write4, mem_addr4, mem_write4 ? mem_data_w4 : data_r4);
      if (q4.size() == 0) begin
        checks++;
        $display("FAIL txn4: unexpected access %0h", act);
      end else chk("txn4", 64'(act), 64'(q4.pop_front()));
      pops4++;
    end
  end
  initial begin
    int n, base;
    rr = 2'b01;
    @(negedge clk);
    chk("rst_wait", req_wait, 2'b01);
    chk("rst_gv", grant_valid, 0);
    chk("rst_en", mem_en, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_gidx", grant_idx, 1);
    chk("rst_gidx4", grant_idx4, 3);
    @(posedge clk); #1;
    rst = 0; rr = 0;
    // port 0 write
    @(posedge clk); #1;
    rw = 2'b01; ra[15:0] = 16'h0010; rd[31:0] = 32'hDEADBEEF;
    q2.push_back(mk(0, 1, 16'h0010, 32'hDEADBEEF));
    @(negedge clk);
    chk("t1_arb_wait", req_wait[0], 1);
    chk("t1_arb_wr", mem_write, 0);
    @(negedge clk);
    chk("t1_wr", mem_write, 1);
    chk("t1_addr", mem_addr, 16'h0010);
    chk("t1_wait", req_wait[0], 0);
    chk("t1_gidx", grant_idx, 0);
    @(posedge clk); #1;
    rw = 0;
    @(negedge clk);
    chk("t1_wr_once", mem_write, 0);
    // port 1 read with two wait cycles
    @(posedge clk); #1;
    wait_n = 2; rr = 2'b10; ra[31:16] = 16'h0010;
    q2.push_back(mk(1, 0, 16'h0010, 32'hDEADBEEF));
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!req_wait[1]) break;
      n++;
    end
    chk("t2_wait_cycles", n, 3);
    chk("t2_data", data_r, 32'hDEADBEEF);
    @(posedge clk); #1;
    rr = 0;
    @(negedge clk);
    chk("t2_idle", grant_valid, 0);
    // both ports reading continuously
    @(posedge clk); #1;
    wait_n = 0; base = pops2;
    for (int i = 0; i < 4; i++) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
      q2.push_back(mk(0, 0, 16'h0010, 32'hDEADBEEF));
`else
      q2.push_back(mk(i % 2, 0, 16'h0010, 32'hDEADBEEF));
`endif
    end
    rr = 2'b11;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); #1;
      if (pops2 >= base + 4) break;
    end
    @(posedge clk); #1;
    rr = 0;
    chk("t3_pops", pops2 - base, 4);
    // reset in the middle of a read
    @(posedge clk); #1;
    wait_n = 5; rr = 2'b01;
    @(negedge clk);
    @(negedge clk);
    chk("t4_busy", grant_valid, 1);
    chk("t4_rd", mem_read, 1);
    @(posedge clk); #1;
    rst = 1;
    @(posedge clk); #1;
    rst = 0; wait_n = 0;
    q2.push_back(mk(0, 0, 16'h0010, 32'hDEADBEEF));
    @(negedge clk);
    chk("t4_rst_gv", grant_valid, 0);
    chk("t4_rst_rd", mem_read, 0);
    chk("t4_rst_gidx", grant_idx, 1);
    @(negedge clk);
    chk("t4_regrant", grant_idx, 0);
    chk("t4_regrant_gv", grant_valid, 1);
    @(posedge clk); #1;
    rr = 0;
    // port 1 abandons a stalled read, port 0 then served
    @(posedge clk); #1;
    wait_n = 5; rr = 2'b10;
    @(negedge clk);
    @(negedge clk);
    chk("t5_gidx", grant_idx, 1);
    chk("t5_mwait", mem_wait, 1);
    chk("t5_rwait", req_wait[1], 1);
    @(posedge clk); #1;
    rr = 2'b01; wait_n = 0;
    q2.push_back(mk(0, 0, 16'h0010, 32'hDEADBEEF));
    @(negedge clk);
    chk("t5_abort_en", mem_en, 0);
    chk("t5_abort_wait0", req_wait[0], 1);
    @(negedge clk);
    chk("t5_idle", grant_valid, 0);
    @(negedge clk);
    chk("t5_p0", grant_idx, 0);
    chk("t5_p0_gv", grant_valid, 1);
    @(posedge clk); #1;
    rr = 0;
    // 4-port wrap-around
    @(posedge clk); #1;
    base = pops4;
    ra4[31:16] = 16'h0101; ra4[63:48] = 16'h0303;
    q4.push_back(mk(1, 0, 16'h0101, 32'hC0DE0101));
    q4.push_back(mk(3, 0, 16'h0303, 32'hC0DE0303));
    rr4 = 4'b1010;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); #1;
      if (pops4 >= base + 2) break;
    end
    @(posedge clk); #1;
    rr4 = 0;
    chk("t6_pops", pops4 - base, 2);
    @(negedge clk);
    chk("q2_empty", q2.size(), 0);
    chk("q4_empty", q4.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
